// File: rtl/rob_commit_if.sv
// ROB head / retirement bundle between the reorder buffer side and rob_commit.
// Latency: none; wires only.
// Backpressure: none; rob_commit pops the head with o_rob_dequeue when it retires it.
//
// Port summary (named from the rob_commit point of view):
//   i_rob_empty, i_rob_head_*      : ROB head state presented to the retire stage
//   o_rob_dequeue                  : pop ROB head this cycle
//   o_free_list_enqueue/_wdata     : physical register returned to the free list
//   o_rrat_map                     : committed mappings, entry i at [i*PR_WIDTH +: PR_WIDTH]
//   o_flush/_pc, o_updated_order   : one-cycle redirect after a mispredicted retire
interface rob_commit_if #(
   parameter int AR_WIDTH = 5,
   parameter int PR_WIDTH = 6,
   parameter int NUM_AR   = 32
);
   logic                       i_rob_empty;
   logic                       i_rob_head_done;
   logic [AR_WIDTH-1:0]        i_rob_head_rd;
   logic [PR_WIDTH-1:0]        i_rob_head_pd;
   logic [63:0]                i_rob_head_order;
   logic                       i_rob_head_mispredict;
   logic [31:0]                i_rob_head_actual_pc;
   logic                       o_rob_dequeue;
   logic                       o_free_list_enqueue;
   logic [PR_WIDTH-1:0]        o_free_list_wdata;
   logic [NUM_AR*PR_WIDTH-1:0] o_rrat_map;
   logic                       o_flush;
   logic [31:0]                o_flush_pc;
   logic [63:0]                o_updated_order;

   // ROB / environment side
   modport master (
      output i_rob_empty, i_rob_head_done, i_rob_head_rd, i_rob_head_pd,
             i_rob_head_order, i_rob_head_mispredict, i_rob_head_actual_pc,
      input  o_rob_dequeue, o_free_list_enqueue, o_free_list_wdata, o_rrat_map,
             o_flush, o_flush_pc, o_updated_order
   );

   // Retire stage side
   modport slave (
      input  i_rob_empty, i_rob_head_done, i_rob_head_rd, i_rob_head_pd,
             i_rob_head_order, i_rob_head_mispredict, i_rob_head_actual_pc,
      output o_rob_dequeue, o_free_list_enqueue, o_free_list_wdata, o_rrat_map,
             o_flush, o_flush_pc, o_updated_order
   );
endinterface

// File: rtl/rob_commit.sv
// In-order retirement of the ROB head: updates the RRAT, frees the superseded preg, flushes on mispredict.
// Latency: dequeue/free same cycle as head done; RRAT visible next cycle; flush 1 cycle after retire.
// Backpressure: stalls while the ROB is empty or the head is not done; no retire in the FLUSH/DRAIN cycles.
//
// Ports: i_clk, i_rst (synchronous, active-high), bus (rob_commit_if.slave, see interface header).
// Optional: define ROB_COMMIT_PERF_EN to add o_perf_commit_count[63:0] and o_perf_flush_count[31:0].
module rob_commit #(
   parameter int AR_WIDTH = 5,
   parameter int PR_WIDTH = 6,
   parameter int NUM_AR   = 32
) (
   input  logic          i_clk,
   input  logic          i_rst,
   rob_commit_if.slave   bus
`ifdef ROB_COMMIT_PERF_EN
   ,
   output logic [63:0]   o_perf_commit_count,
   output logic [31:0]   o_perf_flush_count
`endif
);

   typedef enum logic [1:0] {
      ST_COMMIT = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_retire;
   logic                w_free;
   logic                w_take_flush;

   logic [PR_WIDTH-1:0] r_rrat [NUM_AR];
   logic                r_flush;
   logic [31:0]         r_flush_pc;
   logic [63:0]         r_updated_order;

   // Next state and retire strobes. The strobes are gated by i_rst so nothing
   // leaves the block during a reset cycle even with a done head presented.
   always_comb begin
      w_state_nxt  = r_state;
      w_retire     = 1'b0;
      w_free       = 1'b0;
      w_take_flush = 1'b0;
      case (r_state)
         ST_COMMIT: begin
            w_retire = !i_rst && !bus.i_rob_empty && bus.i_rob_head_done;
            // rd == 0 (stores, plain branches) has no destination to free
            w_free   = w_retire && (bus.i_rob_head_rd != '0);
            if (w_retire && bus.i_rob_head_mispredict) begin
               w_take_flush = 1'b1;
               w_state_nxt  = ST_FLUSH;
            end
         end
         ST_FLUSH: w_state_nxt = ST_DRAIN;
         // DRAIN ignores the head: it may still show stale pre-flush entries
         ST_DRAIN: w_state_nxt = ST_COMMIT;
         default:  w_state_nxt = ST_COMMIT;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_COMMIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // RRAT plus the registered flush outputs. The mispredicted instruction's own
   // mapping lands in the same edge that raises flush, so the RAT copy during
   // the flush cycle already includes it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NUM_AR; i++) begin
            r_rrat[i] <= PR_WIDTH'(i);
         end
         r_flush         <= 1'b0;
         r_flush_pc      <= '0;
         r_updated_order <= '0;
      end else begin
         if (w_free) begin
            r_rrat[bus.i_rob_head_rd] <= bus.i_rob_head_pd;
         end
         r_flush <= w_take_flush;
         // redirect target and order hold their last values outside FLUSH
         if (w_take_flush) begin
            r_flush_pc      <= bus.i_rob_head_actual_pc;
            r_updated_order <= bus.i_rob_head_order;
         end
      end
   end

`ifdef ROB_COMMIT_PERF_EN
   logic [63:0] r_perf_commit_count;
   logic [31:0] r_perf_flush_count;

   // Both counters wrap naturally on overflow
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_perf_commit_count <= '0;
         r_perf_flush_count  <= '0;
      end else begin
         if (w_retire) begin
            r_perf_commit_count <= r_perf_commit_count + 64'd1;
         end
         if (w_take_flush) begin
            r_perf_flush_count <= r_perf_flush_count + 32'd1;
         end
      end
   end

   assign o_perf_commit_count = r_perf_commit_count;
   assign o_perf_flush_count  = r_perf_flush_count;
`endif

   generate
      for (genvar g = 0; g < NUM_AR; g++) begin : g_rrat_map
         assign bus.o_rrat_map[g*PR_WIDTH +: PR_WIDTH] = r_rrat[g];
      end
   endgenerate

   assign bus.o_rob_dequeue       = w_retire;
   assign bus.o_free_list_enqueue = w_free;
   // old mapping, read before this cycle's update
   assign bus.o_free_list_wdata   = r_rrat[bus.i_rob_head_rd];
   assign bus.o_flush             = r_flush;
   assign bus.o_flush_pc          = r_flush_pc;
   assign bus.o_updated_order     = r_updated_order;

endmodule
